// File: rtl/mux_sync_pkg.sv
// mux_sync_pkg
// Shared definitions for the mux/n-flop synchronizer source-side blocks.
//   DW_DEFAULT      : default data bus width
//   HOLD_CYCLES_MIN : smallest legal hold time for mux_sync_src_hold
//   hold_state_t    : pacing FSM state encoding (IDLE, HOLD)
package mux_sync_pkg;

    localparam int DW_DEFAULT      = 8;
    localparam int HOLD_CYCLES_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/mux_sync_hold_timer.sv
// mux_sync_hold_timer
// Loadable down-counter that measures how long a launched word has been held.
// Ports:
//   clk      : source-domain clock
//   rstn     : asynchronous active-low reset (counter clears to 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   tc       : terminal flag, high while the count equals 1 (last hold cycle)
module mux_sync_hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Counts down to 0 and parks there; 0 means "not timing".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == W'(1));

endmodule

// File: rtl/mux_sync_src_hold.sv
// mux_sync_src_hold
// Source-domain pacing stage in front of the mux/n-flop synchronizer. Each
// accepted word is driven on out_data and held for HOLD_CYCLES source cycles;
// in_ready is low while a word is held.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
//   in_valid may drop at any time without a transfer; in_data is only
//   looked at on the transfer edge. in_ready is a registered state decode.
// Ports:
//   clk, rstn : source clock, asynchronous active-low reset
//   in_valid  : upstream word present
//   in_data   : upstream word (DW bits)
//   in_ready  : block can accept a word this cycle
//   out_data  : held word, feeds the synchronizer data input
//   busy      : a word is being held (complement of in_ready)
//   launch    : one-cycle pulse in the first cycle a new value is on out_data
//   word_cnt  : words launched, modulo 2^CNT_W
// Optional feature macro: MUX_SYNC_SRC_HOLD_SKIP_DUP_EN
//   When defined, a word equal to the current out_data is consumed in one
//   cycle with no launch, no count and no hold.
module mux_sync_src_hold
    import mux_sync_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int HOLD_CYCLES = 6,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic             busy,
    output logic             launch,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    generate
        if (HOLD_CYCLES < HOLD_CYCLES_MIN) begin : g_hold_too_small
            $error("mux_sync_src_hold: HOLD_CYCLES must be at least 2");
        end
    endgenerate

    hold_state_t state;
    logic        is_new;
    logic        start;
    logic        tc;

`ifdef MUX_SYNC_SRC_HOLD_SKIP_DUP_EN
    // An unchanged value would produce no new downstream capture.
    assign is_new = (in_data != out_data);
`else
    assign is_new = 1'b1;
`endif

    // in_ready is only high in IDLE, so this is the launch condition.
    assign start = in_valid && in_ready && is_new;

    mux_sync_hold_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (start),
        .load_val (HOLD_LOAD),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            out_data <= '0;
            launch   <= 1'b0;
            word_cnt <= '0;
        end else begin
            launch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        out_data <= in_data;
                        launch   <= 1'b1;
                        word_cnt <= word_cnt + CNT_W'(1);
                        in_ready <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // tc marks the last held cycle; ready again next cycle.
                    if (tc) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy = ~in_ready;

endmodule
